// File: rtl/note_scheduler_if.sv
// Keyboard, chart ROM, dropper pool and score display signals of note_scheduler.
// master = scheduler side, slave = environment side.
interface note_scheduler_if #(
    parameter int unsigned NSLOT = 8
);
    logic [7:0]       keycode;
    logic [7:0]       keycode_second;
    logic [7:0]       chart_addr;
    logic [11:0]      chart_time;
    logic [1:0]       chart_lane;
    logic             chart_last;
    logic [NSLOT-1:0] slot_busy;
    logic [NSLOT-1:0] slot_hit;
    logic [NSLOT-1:0] slot_miss;
    logic [NSLOT-1:0] launch;
    logic [1:0]       launch_lane;
    logic [2:0]       state;
    logic [15:0]      score;
    logic [7:0]       combo;
    logic [7:0]       max_combo;
    logic [7:0]       hit_cnt;
    logic [7:0]       miss_cnt;

    modport master (
        input  keycode, keycode_second, chart_time, chart_lane, chart_last,
               slot_busy, slot_hit, slot_miss,
        output chart_addr, launch, launch_lane, state, score, combo,
               max_combo, hit_cnt, miss_cnt
    );

    modport slave (
        output keycode, keycode_second, chart_time, chart_lane, chart_last,
               slot_busy, slot_hit, slot_miss,
        input  chart_addr, launch, launch_lane, state, score, combo,
               max_combo, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/note_scheduler.sv
// Rhythm-game chart sequencer: launches chart notes into free dropper slots and tallies results.
// Optional pause state (keycode 8'h13) enabled by defining NOTE_SCHED_PAUSE_EN.
module note_scheduler #(
    parameter int unsigned NSLOT      = 8,
    parameter int unsigned HIT_POINTS = 10,
    parameter logic [7:0]  START_KEY  = 8'h2C,
    parameter logic [7:0]  ABORT_KEY  = 8'h01
) (
    input logic              frame_clk,
    input logic              Reset,
    note_scheduler_if.master bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        WAIT   = 3'd2,
        LAUNCH = 3'd3,
        DRAIN  = 3'd4,
`ifdef NOTE_SCHED_PAUSE_EN
        PAUSED = 3'd6,
`endif
        DONE   = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [11:0]      frame_q, frame_d;
    logic [7:0]       addr_q, addr_d;
    logic [NSLOT-1:0] launch_q, launch_d;
    logic [1:0]       lane_q, lane_d;
    logic [15:0]      score_q, score_d;
    logic [7:0]       combo_q, combo_d, maxc_q, maxc_d;
    logic [7:0]       hit_q, hit_d, miss_q, miss_d;

    logic             start_key, abort_key, running, drop;
    logic [NSLOT-1:0] free, free_sel;
    logic [4:0]       h, m;
    logic [31:0]      score_sum;
    logic [8:0]       hit_sum, miss_sum, combo_sum;
    logic [7:0]       combo_new;

    assign start_key = (bus.keycode == START_KEY) || (bus.keycode_second == START_KEY);
    assign abort_key = (bus.keycode == ABORT_KEY) || (bus.keycode_second == ABORT_KEY);
    assign running   = state_q inside {FETCH, WAIT, LAUNCH, DRAIN};
    // Isolate the lowest set bit of the free mask: lowest-numbered free slot.
    assign free      = ~bus.slot_busy;
    assign free_sel  = free & (~free + NSLOT'(1));

`ifdef NOTE_SCHED_PAUSE_EN
    localparam logic [7:0] PAUSE_KEY = 8'h13;
    state_t ret_q, ret_d;
    logic   p_now, p_prev_q, p_rise;
    assign p_now  = (bus.keycode == PAUSE_KEY) || (bus.keycode_second == PAUSE_KEY);
    assign p_rise = p_now && !p_prev_q;
`endif

    always_comb begin
        state_d  = state_q;
        frame_d  = frame_q;
        addr_d   = addr_q;
        launch_d = '0;
        lane_d   = lane_q;
        score_d  = score_q;
        combo_d  = combo_q;
        maxc_d   = maxc_q;
        hit_d    = hit_q;
        miss_d   = miss_q;
        drop     = 1'b0;
`ifdef NOTE_SCHED_PAUSE_EN
        ret_d    = ret_q;
`endif
        case (state_q)
            IDLE: begin
                frame_d = '0;
                addr_d  = '0;
                if (start_key) begin
                    score_d = '0;
                    combo_d = '0;
                    maxc_d  = '0;
                    hit_d   = '0;
                    miss_d  = '0;
                    state_d = FETCH;
                end
            end
            FETCH:  state_d = WAIT;
            WAIT:   if (frame_q >= bus.chart_time) state_d = LAUNCH;
            LAUNCH: begin
                if (free_sel != '0) begin
                    launch_d = free_sel;
                    lane_d   = bus.chart_lane;
                end else begin
                    drop = 1'b1;
                end
                if (bus.chart_last) begin
                    state_d = DRAIN;
                end else begin
                    addr_d  = addr_q + 8'd1;
                    state_d = FETCH;
                end
            end
            DRAIN:  if (bus.slot_busy == '0) state_d = DONE;
            DONE:   state_d = DONE;
`ifdef NOTE_SCHED_PAUSE_EN
            PAUSED: if (p_rise) state_d = ret_q;
`endif
            default: state_d = IDLE;
        endcase

        if (running && frame_q != '1) frame_d = frame_q + 12'd1;

        // Pause and abort both cancel whatever the LAUNCH branch scheduled this cycle.
`ifdef NOTE_SCHED_PAUSE_EN
        if (running && p_rise) begin
            state_d  = PAUSED;
            ret_d    = state_q;
            launch_d = '0;
            lane_d   = lane_q;
            drop     = 1'b0;
            addr_d   = addr_q;
        end
`endif
        if (state_q != IDLE && abort_key) begin
            state_d  = IDLE;
            launch_d = '0;
            lane_d   = lane_q;
            drop     = 1'b0;
            addr_d   = '0;
            frame_d  = '0;
        end

        h         = 5'($countones(bus.slot_hit));
        m         = 5'($countones(bus.slot_miss)) + 5'(drop);
        score_sum = 32'(score_q) + 32'(h) * HIT_POINTS;
        hit_sum   = 9'(hit_q) + 9'(h);
        miss_sum  = 9'(miss_q) + 9'(m);
        combo_sum = (m != '0) ? 9'(h) : 9'(combo_q) + 9'(h);
        combo_new = combo_sum[8] ? 8'hFF : combo_sum[7:0];
        if (state_q != IDLE) begin
            score_d = (score_sum > 32'h0000_FFFF) ? 16'hFFFF : score_sum[15:0];
            hit_d   = hit_sum[8] ? 8'hFF : hit_sum[7:0];
            miss_d  = miss_sum[8] ? 8'hFF : miss_sum[7:0];
            combo_d = combo_new;
            maxc_d  = (combo_new > maxc_q) ? combo_new : maxc_q;
        end
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            frame_q  <= '0;
            addr_q   <= '0;
            launch_q <= '0;
            lane_q   <= '0;
            score_q  <= '0;
            combo_q  <= '0;
            maxc_q   <= '0;
            hit_q    <= '0;
            miss_q   <= '0;
        end else begin
            state_q  <= state_d;
            frame_q  <= frame_d;
            addr_q   <= addr_d;
            launch_q <= launch_d;
            lane_q   <= lane_d;
            score_q  <= score_d;
            combo_q  <= combo_d;
            maxc_q   <= maxc_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
        end
    end

`ifdef NOTE_SCHED_PAUSE_EN
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            ret_q    <= IDLE;
            p_prev_q <= 1'b0;
        end else begin
            ret_q    <= ret_d;
            p_prev_q <= p_now;
        end
    end
`endif

    assign bus.state       = state_q;
    assign bus.chart_addr  = addr_q;
    assign bus.launch      = launch_q;
    assign bus.launch_lane = lane_q;
    assign bus.score       = score_q;
    assign bus.combo       = combo_q;
    assign bus.max_combo   = maxc_q;
    assign bus.hit_cnt     = hit_q;
    assign bus.miss_cnt    = miss_q;
endmodule

// File: tb/tb_note_scheduler.sv
// Directed bench for note_scheduler: launch scoreboard checked by a monitor, plus counter/state checks.
module tb_note_scheduler;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    note_scheduler_if #(.NSLOT(8)) ifc ();

    note_scheduler #(
        .NSLOT(8), .HIT_POINTS(10), .START_KEY(8'h2C), .ABORT_KEY(8'h01)
    ) dut (
        .frame_clk(clk),
        .Reset(rst),
        .bus(ifc.master)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous chart ROM model: data follows the address one cycle later.
    logic [11:0] rom_time [256];
    logic [1:0]  rom_lane [256];
    logic        rom_last [256];
    always @(posedge clk) begin
        ifc.chart_time <= rom_time[ifc.chart_addr];
        ifc.chart_lane <= rom_lane[ifc.chart_addr];
        ifc.chart_last <= rom_last[ifc.chart_addr];
    end

    // Slot pool: manual busy mask plus optional auto-busy on launch.
    logic [7:0] busy_man;
    logic [7:0] busy_auto = '0;
    logic       auto_en;
    always @(posedge clk) busy_auto <= auto_en ? (busy_auto | ifc.launch) : 8'h00;
    assign ifc.slot_busy = busy_man | busy_auto;

    typedef struct {
        logic [7:0] onehot;
        logic [1:0] lane;
        int         at;
    } exp_t;
    exp_t sbq[$];

    always @(negedge clk) begin
        if (!rst && ifc.launch != 8'h00) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL launch_unexpected got=%b lane=%0d cyc=%0d", ifc.launch, ifc.launch_lane, cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if (ifc.launch !== e.onehot || ifc.launch_lane !== e.lane || cyc != e.at) begin
                    errors++;
                    $display("FAIL launch got=%b lane=%0d cyc=%0d exp=%b lane=%0d cyc=%0d",
                             ifc.launch, ifc.launch_lane, cyc, e.onehot, e.lane, e.at);
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic wait_state(input string name, input int st, input int maxc);
        int n = 0;
        while (int'(ifc.state) != st && n < maxc) begin
            tick();
            n++;
        end
        chk(name, int'(ifc.state), st);
    endtask

    task automatic set_rom(input int a, input int t, input int lane, input logic last);
        rom_time[a] = 12'(t);
        rom_lane[a] = 2'(lane);
        rom_last[a] = last;
    endtask

    task automatic press(input logic [7:0] k);
        ifc.keycode = k;
        tick();
        ifc.keycode = 8'h00;
    endtask

    initial begin
        rst = 1'b1;
        ifc.keycode = 8'h2C;
        ifc.keycode_second = 8'h00;
        ifc.slot_hit = 8'h00;
        ifc.slot_miss = 8'h00;
        busy_man = 8'h00;
        auto_en = 1'b0;
        for (int i = 0; i < 256; i++) set_rom(i, 0, 0, 1'b0);
        tick(3);
        chk("reset_state", int'(ifc.state), 0);
        chk("reset_launch", int'(ifc.launch), 0);
        chk("reset_addr", int'(ifc.chart_addr), 0);
        chk("reset_score", int'(ifc.score), 0);
        rst = 1'b0;
        ifc.keycode = 8'h00;
        tick();
        chk("idle_hold", int'(ifc.state), 0);

        // Single note at frame 5 into an empty pool
        set_rom(0, 5, 2, 1'b1);
        sbq.push_back('{8'h01, 2'd2, cyc + 8});
        press(8'h2C);
        chk("t1_fetch", int'(ifc.state), 1);
        wait_state("t1_drain", 4, 20);
        busy_man = 8'h01;
        tick(2);
        chk("t1_drain_hold", int'(ifc.state), 4);
        busy_man = 8'h00;
        tick();
        chk("t1_done", int'(ifc.state), 5);
        press(8'h01);
        chk("t1_abort", int'(ifc.state), 0);

        // Lowest free slot with slots 0..2 busy
        set_rom(0, 0, 1, 1'b1);
        busy_man = 8'h07;
        sbq.push_back('{8'h08, 2'd1, cyc + 4});
        press(8'h2C);
        wait_state("t2_drain", 4, 10);
        tick(2);
        chk("t2_drain_hold", int'(ifc.state), 4);
        busy_man = 8'h00;
        tick();
        chk("t2_done", int'(ifc.state), 5);
        press(8'h01);

        // Full pool drops the note as a miss, then the next note launches
        set_rom(0, 0, 0, 1'b0);
        set_rom(1, 0, 2, 1'b1);
        busy_man = 8'hFF;
        sbq.push_back('{8'h01, 2'd2, cyc + 7});
        press(8'h2C);
        tick(3);
        chk("t3_addr", int'(ifc.chart_addr), 1);
        chk("t3_miss", int'(ifc.miss_cnt), 1);
        chk("t3_combo", int'(ifc.combo), 0);
        chk("t3_fetch", int'(ifc.state), 1);
        busy_man = 8'h00;
        wait_state("t3_drain", 4, 10);
        tick();
        chk("t3_done", int'(ifc.state), 5);
        chk("t3_hits", int'(ifc.hit_cnt), 0);
        press(8'h01);

        // Back-to-back due notes: one every 3 cycles into successive slots
        set_rom(0, 0, 0, 1'b0);
        set_rom(1, 0, 1, 1'b0);
        set_rom(2, 0, 2, 1'b1);
        auto_en = 1'b1;
        sbq.push_back('{8'h01, 2'd0, cyc + 4});
        sbq.push_back('{8'h02, 2'd1, cyc + 7});
        sbq.push_back('{8'h04, 2'd2, cyc + 10});
        press(8'h2C);
        wait_state("t7_drain", 4, 20);
        auto_en = 1'b0;
        tick(2);
        chk("t7_done", int'(ifc.state), 5);
        press(8'h01);

        // Hit/miss accounting while parked in WAIT
        set_rom(0, 12'hFFF, 0, 1'b1);
        press(8'h2C);
        tick();
        chk("t4_wait", int'(ifc.state), 2);
        ifc.slot_hit = 8'h03; tick();
        ifc.slot_hit = 8'h01; tick();
        ifc.slot_hit = 8'h00; tick();
        ifc.slot_hit = 8'h10; tick();
        ifc.slot_hit = 8'h80; tick();
        ifc.slot_hit = 8'h00; tick();
        chk("t4_score", int'(ifc.score), 50);
        chk("t4_combo", int'(ifc.combo), 5);
        chk("t4_hits", int'(ifc.hit_cnt), 5);
        ifc.slot_miss = 8'h04; tick();
        ifc.slot_miss = 8'h00;
        chk("t4_miss_combo", int'(ifc.combo), 0);
        chk("t4_max", int'(ifc.max_combo), 5);
        chk("t4_misses", int'(ifc.miss_cnt), 1);
        ifc.slot_hit = 8'h06; ifc.slot_miss = 8'h01; tick();
        ifc.slot_hit = 8'h00; ifc.slot_miss = 8'h00;
        chk("t4_mixed_combo", int'(ifc.combo), 2);
        chk("t4_mixed_miss", int'(ifc.miss_cnt), 2);
        chk("t4_mixed_score", int'(ifc.score), 70);

        // 7000 hits: saturation of score, hit_cnt, combo
        ifc.slot_hit = 8'hFF;
        tick(30);
        chk("t5_mid_hits", int'(ifc.hit_cnt), 247);
        chk("t5_mid_combo", int'(ifc.combo), 242);
        chk("t5_mid_score", int'(ifc.score), 2470);
        tick(845);
        ifc.slot_hit = 8'h00;
        chk("t5_score_sat", int'(ifc.score), 65535);
        chk("t5_hits_sat", int'(ifc.hit_cnt), 255);
        chk("t5_combo_sat", int'(ifc.combo), 255);
        chk("t5_max_sat", int'(ifc.max_combo), 255);

        // START ignored outside IDLE; ABORT on secondary keycode
        press(8'h2C);
        chk("t6_start_ignored", int'(ifc.state), 2);
        chk("t6_score_kept", int'(ifc.score), 65535);
        ifc.keycode_second = 8'h01; tick();
        ifc.keycode_second = 8'h00;
        chk("t6_abort_idle", int'(ifc.state), 0);
        chk("t6_abort_score", int'(ifc.score), 65535);
        chk("t6_abort_miss", int'(ifc.miss_cnt), 2);
        press(8'h2C);
        chk("t6_restart", int'(ifc.state), 1);
        chk("t6_clr_score", int'(ifc.score), 0);
        chk("t6_clr_hits", int'(ifc.hit_cnt), 0);
        chk("t6_clr_miss", int'(ifc.miss_cnt), 0);
        chk("t6_clr_max", int'(ifc.max_combo), 0);
        chk("t6_addr", int'(ifc.chart_addr), 0);
        press(8'h01);
        tick(2);

        chk("sb_drained", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/note_scheduler.md
Name: note_scheduler

Overview:
Chart sequencer for the rhythm game. It reads note events (frame time, lane) from an external synchronous chart ROM and runs a frame counter after the start key. It launches each note into the lowest-numbered free arrow-dropper slot of a shared pool, then collects per-slot hit/miss results into score, combo and hit/miss counters. It sits between the keyboard interface, the dropper pool and the score display.

Parameters:
NSLOT, 8, number of dropper slots in the pool (1..16)
HIT_POINTS, 10, score added per hit
START_KEY, 8'h2C, keycode that starts a song (space)
ABORT_KEY, 8'h01, keycode that returns to IDLE from any non-IDLE state

Ports:
frame_clk  in  1  clock (frame rate)
Reset  in  1  synchronous, active-high
keycode  in  8  primary USB keycode
keycode_second  in  8  secondary USB keycode
chart_addr  out  8  chart ROM address
chart_time  in  12  note launch frame; valid 1 cycle after chart_addr changes
chart_lane  in  2  note lane (0..3)
chart_last  in  1  this entry is the final note
slot_busy  in  NSLOT  slot k currently owns a falling arrow
slot_hit  in  NSLOT  1-cycle pulse: slot k scored a hit and freed
slot_miss  in  NSLOT  1-cycle pulse: slot k reached bottom unhit and freed
launch  out  NSLOT  one-hot 1-cycle launch pulse
launch_lane  out  2  lane for the launched note; valid with launch
state  out  3  current FSM state encoding
score  out  16  accumulated score
combo  out  8  current combo
max_combo  out  8  best combo this song
hit_cnt  out  8  hits this song
miss_cnt  out  8  misses, including dropped notes

Behaviour:
- Reset:
  - state=IDLE; all outputs 0 (launch=0, launch_lane=0, chart_addr=0, counters=0).
  - Reset has priority over every event.
- Key match: true if keycode or keycode_second equals the key.
- Internal frame counter: 12-bit frame_cnt.
- States:
  - IDLE (0): frame_cnt=0, chart_addr=0. Slot results are ignored. On START_KEY: clear score, combo, max_combo, hit_cnt, miss_cnt; go to FETCH.
  - FETCH (1): one cycle for ROM latency; go to WAIT.
  - WAIT (2): go to LAUNCH when frame_cnt >= chart_time.
  - LAUNCH (3): select lowest index k with slot_busy[k]=0.
    - Slot found: next cycle launch[k]=1 and launch_lane=chart_lane.
    - No free slot: the note is dropped and counted as one miss (miss_cnt+1, combo=0); no launch pulse.
    - Then: if chart_last, go to DRAIN; else chart_addr+1 and go to FETCH.
  - DRAIN (4): go to DONE when slot_busy is all zero.
  - DONE (5): frame_cnt frozen; counters hold.
- Frame counter: frame_cnt increments by 1 each cycle in FETCH/WAIT/LAUNCH/DRAIN and saturates at 4095.
- ABORT_KEY:
  - In any state except IDLE, go to IDLE next cycle.
  - A launch pulse already registered still completes.
  - Counters hold until the next START_KEY.
- START_KEY outside IDLE is ignored.
- Slot contract: a slot raises slot_busy no later than 1 cycle after its launch pulse. The FETCH→WAIT→LAUNCH path guarantees at least 2 cycles between consecutive launches, so a just-launched slot is never picked twice.
- Notes with equal or past chart_time launch back-to-back, one per 3 cycles.
- Result accounting, per cycle in FETCH..DONE:
  - h = popcount(slot_hit), m = popcount(slot_miss); dropped-note miss adds 1 to m.
  - score += h*HIT_POINTS, saturating at 16'hFFFF.
  - hit_cnt += h and miss_cnt += m, each saturating at 255.
  - combo: if m>0, combo = h (misses applied first); else combo = combo + h. Saturates at 255.
  - max_combo = max(max_combo, new combo), updated in the same cycle.
- chart_addr wraps 255→0 if no chart_last is seen; playback continues (no error state).

Optional Feature:
- Macro: NOTE_SCHED_PAUSE_EN.
- When defined, adds PAUSED state (6). Keycode 8'h13 ('P') seen in FETCH/WAIT/LAUNCH/DRAIN enters PAUSED, remembering the return state.
- In PAUSED:
  - frame_cnt frozen; no launches.
  - Slot results are still accounted.
  - 'P' released then pressed again returns to the saved state; ABORT_KEY goes to IDLE.
- When undefined, 8'h13 has no effect and state never equals 6.

Test Plan:
- Reset, then keycode=8'h2C; chart {t=5,lane=2,last=1}; slot_busy=0 → launch=8'b00000001 with launch_lane=2 once frame_cnt>=5; DRAIN→DONE after busy clears.
- slot_busy=8'b00000111, note due → launch=8'b00001000.
- slot_busy=8'hFF, note due → no launch pulse, miss_cnt=1, combo=0, chart_addr advances.
- slot_hit pulses on slots 0,1 in one cycle, then 3 single hits → score=50, combo=5, hit_cnt=5; then a slot_miss pulse → combo=0, max_combo=5.
- 7000 hits streamed (HIT_POINTS=10) → score saturates at 65535; hit_cnt and combo saturate at 255.
- keycode_second=8'h01 mid-WAIT → state=IDLE next cycle, counters hold; keycode=8'h2C → counters cleared, chart_addr=0.
